// File: rtl/com_data_loader.sv
// com_data_loader: host byte link -> little-endian 32-bit words -> data_mem write port.
// Optional trailer checksum enabled by defining the macro CHECKSUM_EN.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   load_en               host level, high while a load session is wanted
//   rx_strobe, rx_data    asynchronous host byte strobe and its 8-bit data
//   mem_we/addr/wdata     one-cycle write into data_mem
//   cpu_hold              high while a session is in progress
//   load_done             high from session end until load_en falls
//   chk_err               sticky trailer mismatch (0 when CHECKSUM_EN is undefined)
module com_data_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          NUM_WORDS   = 16,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        rx_strobe,
    input  logic [7:0]  rx_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        chk_err
);
    localparam int WW = $clog2(NUM_WORDS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   strobe_q;
    logic                   load_en_q;
    logic                   rx_edge;
    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic [1:0]             byte_idx;
    logic [WW-1:0]          word_idx;
    logic                   last_word;
    logic                   pend;
    logic [7:0]             pend_byte;
`ifdef CHECKSUM_EN
    logic [7:0]             csum;
`endif

    // A byte is available either from a fresh edge or from one that
    // arrived while the word was being written.
    assign rx_edge   = sync_q[SYNC_STAGES-1] & ~strobe_q;
    assign rx_valid  = pend | rx_edge;
    assign rx_byte   = pend ? pend_byte : rx_data;
    assign last_word = (word_idx == WW'(NUM_WORDS - 1));

`ifndef CHECKSUM_EN
    assign chk_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            strobe_q  <= 1'b0;
            load_en_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_strobe};
            strobe_q  <= sync_q[SYNC_STAGES-1];
            load_en_q <= load_en;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            byte_idx  <= '0;
            word_idx  <= '0;
            pend      <= 1'b0;
            pend_byte <= '0;
`ifdef CHECKSUM_EN
            csum      <= '0;
            chk_err   <= 1'b0;
`endif
        end else begin
            mem_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_en && !load_en_q) begin
                        state     <= RECV;
                        cpu_hold  <= 1'b1;
                        byte_idx  <= '0;
                        word_idx  <= '0;
                        mem_addr  <= BASE_ADDR;
                        mem_wdata <= '0;
                        pend      <= 1'b0;
`ifdef CHECKSUM_EN
                        csum      <= '0;
                        chk_err   <= 1'b0;
`endif
                    end
                end
                RECV: begin
                    if (!load_en) begin
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                        pend     <= 1'b0;
                    end else begin
                        if (rx_valid) begin
                            mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_byte;
`ifdef CHECKSUM_EN
                            csum <= csum ^ rx_byte;
`endif
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                state  <= WRITE;
                                mem_we <= 1'b1;
                            end
                        end
                        // A pending byte is consumed now; a simultaneous
                        // fresh edge takes its place.
                        if (pend) begin
                            pend      <= rx_edge;
                            pend_byte <= rx_data;
                        end
                    end
                end
                WRITE: begin
                    if (!load_en) begin
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                        pend     <= 1'b0;
                    end else begin
                        if (rx_edge) begin
                            pend      <= 1'b1;
                            pend_byte <= rx_data;
                        end
                        word_idx <= word_idx + 1'b1;
                        if (last_word) begin
`ifdef CHECKSUM_EN
                            state <= CHECK;
`else
                            state     <= DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
`endif
                        end else begin
                            state    <= RECV;
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                CHECK: begin
`ifdef CHECKSUM_EN
                    if (!load_en) begin
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                        pend     <= 1'b0;
                    end else if (rx_valid) begin
                        chk_err   <= (rx_byte != csum);
                        state     <= DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                        pend      <= 1'b0;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    if (!load_en) begin
                        state     <= IDLE;
                        load_done <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
